// File: rtl/logical_tile_ccff_bitstream_loader_if.sv
// logical_tile_ccff_bitstream_loader_if: parallel bitstream word stream feeding the loader
interface logical_tile_ccff_bitstream_loader_if #(parameter int WORD_W = 8);
  logic [WORD_W-1:0] s_data;
  logic s_valid;
  logic s_ready;
  modport master(output s_data, output s_valid, input s_ready);
  modport slave(input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/logical_tile_ccff_bitstream_loader.sv
// logical_tile_ccff_bitstream_loader: serialises bitstream words MSB-first into a CCFF configuration chain
module logical_tile_ccff_bitstream_loader #(
  parameter int WORD_W = 8,
  parameter int CHAIN_LEN = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  logical_tile_ccff_bitstream_loader_if.slave s,
  output logic ccff_head,
  output logic prog_en,
  output logic busy,
  output logic done
);
  localparam int SW = $clog2(WORD_W + 1);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int MW = SW > CW ? SW : CW;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state;
  logic [WORD_W-1:0] sr;
  logic [SW-1:0] sr_cnt;
  logic [CW-1:0] chain_cnt;
  logic pop, xfer;
  assign pop = state == LOAD && sr_cnt != '0 && chain_cnt != '0;
  // refill only when the register is empty or on its last bit, and only if the chain still needs more bits
  assign s.s_ready = state == LOAD && sr_cnt <= SW'(1) && MW'(chain_cnt) > MW'(sr_cnt);
  assign xfer = s.s_valid && s.s_ready;
  assign busy = state == LOAD;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      sr_cnt <= '0;
      chain_cnt <= '0;
      ccff_head <= 1'b0;
      prog_en <= 1'b0;
      done <= 1'b0;
    end else begin
      prog_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            state <= LOAD;
            chain_cnt <= CW'(CHAIN_LEN);
            sr_cnt <= '0;
          end
        LOAD:
          if (abort) begin
            state <= IDLE;
            sr <= '0;
            sr_cnt <= '0;
            chain_cnt <= '0;
          end else begin
            if (pop) begin
              ccff_head <= sr[WORD_W-1];
              prog_en <= 1'b1;
              chain_cnt <= chain_cnt - CW'(1);
            end
            if (xfer) begin
              sr <= s.s_data;
              sr_cnt <= SW'(WORD_W);
            end else if (pop) begin
              sr <= sr << 1;
              sr_cnt <= sr_cnt - SW'(1);
            end
            // leftover bits of the final word are simply abandoned here
            if (pop && chain_cnt == CW'(1)) begin
              state <= DONE;
              done <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_logical_tile_ccff_bitstream_loader.sv
// tb_logical_tile_ccff_bitstream_loader: table-driven and randomised checks of the CCFF loader
module tb_logical_tile_ccff_bitstream_loader;
  logic clk = 1'b0;
  logic reset, start, abort, start2, abort2;
  logic ccff_head, prog_en, busy, done, h2, pe2, b2, d2;
  always #5 clk = ~clk;
  logical_tile_ccff_bitstream_loader_if #(.WORD_W(8)) bus ();
  logical_tile_ccff_bitstream_loader_if #(.WORD_W(8)) bus2 ();
  logical_tile_ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .s(bus.slave),
    .ccff_head(ccff_head), .prog_en(prog_en), .busy(busy), .done(done));
  logical_tile_ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2), .s(bus2.slave),
    .ccff_head(h2), .prog_en(pe2), .busy(b2), .done(d2));

  typedef struct {
    logic [23:0] w;
    logic [11:0] g;
    int kind;
    int at;
    logic [63:0] bits;
    int pe;
    int span;
    int dn;
  } vec_t;
  vec_t tbl[6];
  vec_t v;
  int checks = 0, errors = 0, cyc = 0;
  int pe_cnt, done_cnt, first_c, last_c, pe2c, d2c;
  logic [63:0] sh, sh2;

  always @(negedge clk) begin
    cyc++;
    if (prog_en) begin
      sh = {sh[62:0], ccff_head};
      if (pe_cnt == 0) first_c = cyc;
      last_c = cyc;
      pe_cnt++;
    end
    if (done) done_cnt++;
    if (pe2) begin
      sh2 = {sh2[62:0], h2};
      pe2c++;
    end
    if (d2) d2c++;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clr;
    sh = '0;
    pe_cnt = 0;
    done_cnt = 0;
    first_c = 0;
    last_c = 0;
    sh2 = '0;
    pe2c = 0;
    d2c = 0;
  endtask

  // kind: 0 plain load, 1 abort after 'at' bits, 2 reset after 'at' bits, 3 stray start pulses
  task automatic run(input vec_t x, input string nm);
    int i, k;
    logic fired, rdy_late;
    i = 0;
    k = int'(x.g[11:8]);
    fired = 1'b0;
    rdy_late = 1'b0;
    clr;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (abort || reset) begin
        abort = 1'b0;
        reset = 1'b0;
        chk({nm, " evt prog_en"}, 64'(prog_en), 0);
        chk({nm, " evt busy"}, 64'(busy), 0);
        chk({nm, " evt s_ready"}, 64'(bus.s_ready), 0);
        if (x.kind == 2) chk({nm, " evt ccff_head"}, 64'(ccff_head), 0);
      end
      if (fired && bus.s_ready) rdy_late = 1'b1;
      if (bus.s_valid) begin
        bus.s_valid = 1'b0;
        i++;
        if (i < 3) k = int'(x.g[11-4*i -: 4]);
      end else if (i < 3 && bus.s_ready) begin
        if (k == 0) begin
          bus.s_valid = 1'b1;
          bus.s_data = x.w[23-8*i -: 8];
        end else k--;
      end
      if (!fired && (x.kind == 1 || x.kind == 2) && pe_cnt == x.at) begin
        fired = 1'b1;
        if (x.kind == 1) abort = 1'b1;
        else reset = 1'b1;
      end
      start = x.kind == 3 && (t == 6 || done);
      tick;
    end
    bus.s_valid = 1'b0;
    chk({nm, " bits"}, sh, x.bits);
    chk({nm, " prog_en count"}, 64'(pe_cnt), 64'(x.pe));
    chk({nm, " span"}, 64'(last_c - first_c + 1), 64'(x.span));
    chk({nm, " done count"}, 64'(done_cnt), 64'(x.dn));
    chk({nm, " idle busy"}, 64'(busy), 0);
    chk({nm, " idle s_ready"}, 64'(bus.s_ready), 0);
    if (x.kind == 1 || x.kind == 2) chk({nm, " s_ready after evt"}, 64'(rdy_late), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [23:0] w;
    logic [11:0] g;
    int rdy2;
    logic got2;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    start2 = 1'b0;
    abort2 = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus2.s_valid = 1'b0;
    bus2.s_data = '0;
    clr;
    repeat (3) tick;
    chk("reset prog_en", 64'(prog_en), 0);
    chk("reset ccff_head", 64'(ccff_head), 0);
    chk("reset busy", 64'(busy), 0);
    chk("reset done", 64'(done), 0);
    chk("reset s_ready", 64'(bus.s_ready), 0);
    reset = 1'b0;
    tick;
    chk("idle s_ready", 64'(bus.s_ready), 0);
    tbl[0] = '{24'hA53CF0, 12'h000, 0, 0, 64'hA53CF, 20, 20, 1};
    tbl[1] = '{24'hA53CF0, 12'h333, 0, 0, 64'hA53CF, 20, 26, 1};
    tbl[2] = '{24'hA53CF0, 12'h000, 1, 10, 64'h294, 10, 10, 0};
    tbl[3] = '{24'hA53CF0, 12'h000, 0, 0, 64'hA53CF, 20, 20, 1};
    tbl[4] = '{24'hA53CF0, 12'h000, 2, 12, 64'hA53, 12, 12, 0};
    tbl[5] = '{24'hA53CF0, 12'h120, 3, 0, 64'hA53CF, 20, 22, 1};
    for (int n = 0; n < 6; n++) begin
      run(tbl[n], $sformatf("vec%0d", n));
      repeat (2) tick;
    end
    // reference: chain receives the top 20 bits of the word stream; each stall adds its length to the span
    for (int n = 0; n < 10; n++) begin
      w = 24'($urandom);
      g = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
      v = '{w, g, 0, 0, 64'(w >> 4), 20, 20 + int'(g[7:4]) + int'(g[3:0]), 1};
      run(v, $sformatf("rand%0d", n));
      tick;
    end
    clr;
    rdy2 = 0;
    got2 = 1'b0;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bus2.s_valid) begin
        bus2.s_valid = 1'b0;
        got2 = 1'b1;
      end else if (!got2 && bus2.s_ready) begin
        bus2.s_valid = 1'b1;
        bus2.s_data = 8'h81;
      end
      if (got2 && bus2.s_ready) rdy2++;
      tick;
    end
    chk("len8 bits", sh2, 64'h81);
    chk("len8 prog_en count", 64'(pe2c), 8);
    chk("len8 done count", 64'(d2c), 1);
    chk("len8 s_ready reasserted", 64'(rdy2), 0);
    chk("len8 busy", 64'(b2), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/logical_tile_ccff_bitstream_loader.md
LOGICAL_TILE_CCFF_BITSTREAM_LOADER -- requirements
Module: logical_tile_ccff_bitstream_loader

Interface
REQ-001 Parameter WORD_W, default 8: width of each parallel bitstream word.
REQ-002 Parameter CHAIN_LEN, default 20: number of configuration bits in the downstream chain (CHAIN_LEN >= 1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin loading a new bitstream.
REQ-006 abort  input  1  synchronous cancel of the load in progress.
REQ-007 s_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  loader accepts s_data this cycle.
REQ-010 ccff_head  output  1  serial configuration bit to the chain head (registered).
REQ-011 prog_en  output  1  chain shift enable: chain shifts ccff_head on the next clk edge when high (registered).
REQ-012 busy  output  1  high in LOAD state.
REQ-013 done  output  1  one-cycle pulse when exactly CHAIN_LEN bits have been shifted.

Function
REQ-014 The block SHALL have states IDLE, LOAD, DONE; a word transfer occurs on any cycle with s_valid=1 and s_ready=1.
REQ-015 IDLE -> LOAD on start=1; on entry, chain_cnt := CHAIN_LEN and sr_cnt := 0; start in LOAD or DONE is ignored.
REQ-016 The block SHALL hold a WORD_W shift register sr, a bit counter sr_cnt (0..WORD_W) and a remaining-bit counter chain_cnt (0..CHAIN_LEN), each sized to $clog2(max+1).
REQ-017 s_ready SHALL be combinational: 1 only in LOAD with (sr_cnt==0 or sr_cnt==1) and chain_cnt > sr_cnt; 0 in IDLE and DONE.
REQ-018 Pop: in LOAD, on a cycle with sr_cnt>0 and chain_cnt>0, the next edge SHALL set ccff_head := sr[WORD_W-1], prog_en := 1, shift sr left by one, and decrement sr_cnt and chain_cnt.
REQ-019 On any edge without a pop, prog_en SHALL be 0 and ccff_head SHALL hold its value.
REQ-020 Transfer with sr_cnt==0: sr := s_data, sr_cnt := WORD_W; no pop that cycle.
REQ-021 Transfer with sr_cnt==1: the remaining bit SHALL pop, sr := s_data and sr_cnt := WORD_W on the same edge, so back-to-back valid words give continuous prog_en with no bubble.
REQ-022 Source stall (s_valid=0 with sr_cnt==0) SHALL hold prog_en at 0 and preserve all counters; no timeout applies.
REQ-023 Last word: once chain_cnt reaches 0, any unshifted bits in sr SHALL be discarded; only the top chain_cnt bits of the final word are used.
REQ-024 The edge that drives chain_cnt to 0 SHALL move LOAD -> DONE; in DONE, done=1 for exactly one cycle, prog_en=0, then -> IDLE.
REQ-025 abort=1 in LOAD SHALL move to IDLE on the next edge, clear sr, sr_cnt, chain_cnt and prog_en, and assert no done; abort has priority over a pop or transfer in the same cycle; abort in IDLE or DONE has no effect.
REQ-026 The total number of prog_en=1 cycles per completed load SHALL equal CHAIN_LEN exactly.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, sr=0, sr_cnt=0, chain_cnt=0, ccff_head=0, prog_en=0, done=0, busy=0, s_ready=0, and SHALL take priority over start, abort and transfers.
REQ-028 reset asserted mid-LOAD SHALL discard the partial load; no done pulse follows.

Verification (WORD_W=8, CHAIN_LEN=20)
REQ-029 start; words 0xA5, 0x3C, 0xF0 offered back-to-back -> prog_en high for 20 consecutive cycles; ccff_head = 10100101 00111100 1111; low nibble of 0xF0 discarded; then one done pulse.
REQ-030 Same words with s_valid dropped 3 cycles between words -> prog_en gaps of 3 cycles; bit sequence unchanged; exactly 20 prog_en cycles total; done once.
REQ-031 abort asserted after 10 bits shifted -> IDLE next edge; prog_en=0; no done; a following start and full load completes normally with 20 bits.
REQ-032 reset asserted during second word -> all outputs 0 next edge; s_ready=0 until next start.
REQ-033 start pulsed during LOAD and during DONE -> ignored; chain_cnt not reloaded; single done per load.
REQ-034 CHAIN_LEN=8, single word 0x81 -> exactly 8 prog_en cycles, bits 1,0,0,0,0,0,0,1; s_ready never reasserted after the first transfer.
